alu_cmd_seq: RTL and testbench

- Upstream command sequencer that feeds simple_alu.
- Accepts parallel ALU commands (opcode, operand A, operand B) over a valid/ready interface and buffers them in a small FIFO.
- Serializes each command onto the ALU's opcode_valid/opcode/data pins, waits for done, and returns result and overflow on a valid/ready response port.
- Adds a done-timeout so a hung ALU cannot stall the stream.

---
 rtl/alu_cmd_seq.sv | 174 +++++++++++++++++
 tb/tb_alu_cmd_seq.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_seq.sv
// Command sequencer for simple_alu: buffers commands, serialises them onto the ALU pins and returns responses.
// Optional statistics outputs are enabled by defining ALU_SEQ_STATS_EN.
module alu_cmd_seq #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_op,
    input  logic [DATA_WIDTH-1:0] cmd_a,
    input  logic [DATA_WIDTH-1:0] cmd_b,
    output logic                  opcode_valid,
    output logic                  opcode,
    output logic [DATA_WIDTH-1:0] data,
    input  logic                  done,
    input  logic                  overflow,
    input  logic [DATA_WIDTH-1:0] result,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_result,
    output logic                  rsp_overflow,
`ifdef ALU_SEQ_STATS_EN
    output logic [15:0]           stat_cmd_cnt,
    output logic [15:0]           stat_ovf_cnt,
    output logic [15:0]           stat_tmo_cnt,
`endif
    output logic                  rsp_timeout
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = 2 * DATA_WIDTH + 1;
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, SEND_A, SEND_B, WAIT_DONE, RESP} state_t;

    state_t                state, next_state;
    logic [EW-1:0]         fifo_mem [FIFO_DEPTH];
    logic [AW:0]           wr_ptr, rd_ptr;
    logic                  full, empty, push, pop;
    logic                  hold_op;
    logic [DATA_WIDTH-1:0] hold_a, hold_b;
    logic [7:0]            tmo_cnt;
    logic                  tmo_hit;

    // Extra wrap bit: equal low bits with differing top bit means full.
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty     = (wr_ptr == rd_ptr);
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;
    assign pop       = (state == IDLE) && !empty;
    assign tmo_hit   = (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr[AW-1:0]] <= {cmd_op, cmd_a, cmd_b};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            hold_op <= 1'b0;
            hold_a  <= '0;
            hold_b  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
                {hold_op, hold_a, hold_b} <= fifo_mem[rd_ptr[AW-1:0]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state   = state;
        opcode_valid = 1'b0;
        opcode       = 1'b0;
        data         = '0;
        rsp_valid    = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    next_state = SEND_A;
                end
            end
            SEND_A: begin
                opcode_valid = 1'b1;
                opcode       = hold_op;
                data         = hold_a;
                next_state   = SEND_B;
            end
            SEND_B: begin
                opcode_valid = 1'b1;
                opcode       = hold_op;
                data         = hold_b;
                next_state   = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (done || tmo_hit) begin
                    next_state = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // A done on the limit cycle takes priority over the timeout.
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt      <= '0;
            rsp_result   <= '0;
            rsp_overflow <= 1'b0;
            rsp_timeout  <= 1'b0;
        end else if (state == SEND_B) begin
            tmo_cnt <= '0;
        end else if (state == WAIT_DONE) begin
            if (done) begin
                rsp_result   <= result;
                rsp_overflow <= overflow;
                rsp_timeout  <= 1'b0;
            end else if (tmo_hit) begin
                rsp_result   <= '0;
                rsp_overflow <= 1'b0;
                rsp_timeout  <= 1'b1;
            end else begin
                tmo_cnt <= tmo_cnt + 8'd1;
            end
        end
    end

`ifdef ALU_SEQ_STATS_EN
    logic rsp_fire;
    assign rsp_fire = rsp_valid && rsp_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_cmd_cnt <= '0;
            stat_ovf_cnt <= '0;
            stat_tmo_cnt <= '0;
        end else if (rsp_fire) begin
            if (stat_cmd_cnt != 16'hFFFF) begin
                stat_cmd_cnt <= stat_cmd_cnt + 16'd1;
            end
            if (rsp_overflow && stat_ovf_cnt != 16'hFFFF) begin
                stat_ovf_cnt <= stat_ovf_cnt + 16'd1;
            end
            if (rsp_timeout && stat_tmo_cnt != 16'hFFFF) begin
                stat_tmo_cnt <= stat_tmo_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_cmd_seq.sv
// Directed self-checking bench for alu_cmd_seq with a behavioural ALU responder.
// Stats outputs are checked only when ALU_SEQ_STATS_EN is defined.
module tb_alu_cmd_seq;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int TMO   = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid, cmd_ready, cmd_op;
    logic [DW-1:0] cmd_a, cmd_b;
    logic          opcode_valid, opcode;
    logic [DW-1:0] data;
    logic          done, overflow;
    logic [DW-1:0] result;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_result;
    logic          rsp_overflow, rsp_timeout;
`ifdef ALU_SEQ_STATS_EN
    logic [15:0]   stat_cmd_cnt, stat_ovf_cnt, stat_tmo_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    bit            alu_enable = 1'b1;
    int            alu_delay  = 0;
    logic          cap_op;
    logic [DW-1:0] cap_a, cap_b;
    bit            seen_a, pending;
    int            wait_cnt;

    always #5 clk = ~clk;

    alu_cmd_seq #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b),
        .opcode_valid(opcode_valid), .opcode(opcode), .data(data),
        .done(done), .overflow(overflow), .result(result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_overflow(rsp_overflow),
`ifdef ALU_SEQ_STATS_EN
        .stat_cmd_cnt(stat_cmd_cnt), .stat_ovf_cnt(stat_ovf_cnt), .stat_tmo_cnt(stat_tmo_cnt),
`endif
        .rsp_timeout(rsp_timeout)
    );

    function automatic logic [DW:0] alu_calc(input logic op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW-1:0] s;
        logic          v;
        s = op ? (a - b) : (a + b);
        if (op) v = (a[DW-1] != b[DW-1]) && (s[DW-1] != a[DW-1]);
        else    v = (a[DW-1] == b[DW-1]) && (s[DW-1] != a[DW-1]);
        return {v, s};
    endfunction

    // Behavioural ALU: collects A/B from the two valid cycles, then strobes done alu_delay cycles into the wait.
    initial begin
        done = 1'b0; overflow = 1'b0; result = '0;
        seen_a = 1'b0; pending = 1'b0; wait_cnt = 0;
        forever begin
            @(negedge clk);
            done = 1'b0; overflow = 1'b0; result = '0;
            if (reset) begin
                seen_a = 1'b0; pending = 1'b0;
            end else if (opcode_valid && !seen_a) begin
                cap_op = opcode; cap_a = data; seen_a = 1'b1; pending = 1'b0;
            end else if (opcode_valid) begin
                cap_b = data; seen_a = 1'b0; pending = 1'b1; wait_cnt = 0;
            end else if (pending) begin
                if (alu_enable && wait_cnt == alu_delay) begin
                    done = 1'b1;
                    {overflow, result} = alu_calc(cap_op, cap_a, cap_b);
                    pending = 1'b0;
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        int guard = 0;
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
        while (!cmd_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) checkOutput("push_accept", 32'd0, 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic waitResponse(input string tag, input logic [DW-1:0] exp_res, input logic exp_ovf, input logic exp_tmo);
        int guard = 0;
        while (!rsp_valid && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        if (!rsp_valid) begin
            checkOutput({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
        end else begin
            checkOutput({tag, "_result"},   32'(rsp_result),   32'(exp_res));
            checkOutput({tag, "_overflow"}, 32'(rsp_overflow), 32'(exp_ovf));
            checkOutput({tag, "_timeout"},  32'(rsp_timeout),  32'(exp_tmo));
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cyc;
        int seen_rsp, seen_op;
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_a = '0; cmd_b = '0; rsp_ready = 1'b1;

        // Reset values while reset is still held.
        repeat (3) @(negedge clk);
        checkOutput("rst_cmd_ready",    32'(cmd_ready),    32'd1);
        checkOutput("rst_opcode_valid", 32'(opcode_valid), 32'd0);
        checkOutput("rst_opcode",       32'(opcode),       32'd0);
        checkOutput("rst_data",         32'(data),         32'd0);
        checkOutput("rst_rsp_valid",    32'(rsp_valid),    32'd0);
        checkOutput("rst_rsp_result",   32'(rsp_result),   32'd0);
        checkOutput("rst_rsp_timeout",  32'(rsp_timeout),  32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Single add with exact pin-level timing.
        alu_delay = 2;
        applyStimulus(1'b0, 8'h12, 8'h34);
        checkOutput("t1_idle_after_push", 32'(opcode_valid), 32'd0);
        @(negedge clk);
        checkOutput("t1_senda_valid", 32'(opcode_valid), 32'd1);
        checkOutput("t1_senda_op",    32'(opcode),       32'd0);
        checkOutput("t1_senda_data",  32'(data),         32'h12);
        @(negedge clk);
        checkOutput("t1_sendb_valid", 32'(opcode_valid), 32'd1);
        checkOutput("t1_sendb_data",  32'(data),         32'h34);
        @(negedge clk);
        checkOutput("t1_wait_valid",  32'(opcode_valid), 32'd0);
        checkOutput("t1_wait_data",   32'(data),         32'h00);
        waitResponse("t1", 8'h46, 1'b0, 1'b0);

        // Five back-to-back commands with the response port stalled.
        alu_delay = 0;
        rsp_ready = 1'b0;
        applyStimulus(1'b0, 8'h01, 8'h02);
        applyStimulus(1'b1, 8'h10, 8'h03);
        applyStimulus(1'b0, 8'hF0, 8'h20);
        applyStimulus(1'b1, 8'h80, 8'h01);
        checkOutput("t2_ready_after_4", 32'(cmd_ready), 32'd1);
        applyStimulus(1'b0, 8'h55, 8'hAA);
        checkOutput("t2_ready_after_5", 32'(cmd_ready), 32'd0);
        repeat (4) @(negedge clk);
        checkOutput("t2_stall_valid",  32'(rsp_valid),  32'd1);
        checkOutput("t2_stall_result", 32'(rsp_result), 32'h03);
        checkOutput("t2_stall_full",   32'(cmd_ready),  32'd0);
        rsp_ready = 1'b1;
        waitResponse("t2_r0", 8'h03, 1'b0, 1'b0);
        waitResponse("t2_r1", 8'h0D, 1'b0, 1'b0);
        waitResponse("t2_r2", 8'h10, 1'b0, 1'b0);
        waitResponse("t2_r3", 8'h7F, 1'b1, 1'b0);
        waitResponse("t2_r4", 8'hFF, 1'b0, 1'b0);

        // Signed overflow on add.
        applyStimulus(1'b0, 8'h7F, 8'h01);
        waitResponse("t3", 8'h80, 1'b1, 1'b0);

        // Hung ALU: response exactly TMO cycles after entering the wait.
        alu_enable = 1'b0;
        applyStimulus(1'b0, 8'hAA, 8'hBB);
        cyc = 0;
        while (!opcode_valid && cyc < 20) begin @(negedge clk); cyc++; end
        @(negedge clk);
        @(negedge clk);
        cyc = 0;
        while (!rsp_valid && cyc < 40) begin @(negedge clk); cyc++; end
        checkOutput("t4_tmo_cycles",   32'(cyc),          32'(TMO));
        checkOutput("t4_tmo_flag",     32'(rsp_timeout),  32'd1);
        checkOutput("t4_tmo_result",   32'(rsp_result),   32'd0);
        checkOutput("t4_tmo_overflow", 32'(rsp_overflow), 32'd0);
        @(negedge clk);

        // done on the final allowed wait cycle still yields a normal response.
        alu_enable = 1'b1;
        alu_delay  = TMO - 1;
        applyStimulus(1'b0, 8'h20, 8'h30);
        cyc = 0;
        while (!opcode_valid && cyc < 20) begin @(negedge clk); cyc++; end
        @(negedge clk);
        @(negedge clk);
        cyc = 0;
        while (!rsp_valid && cyc < 40) begin @(negedge clk); cyc++; end
        checkOutput("t4_late_cycles", 32'(cyc),         32'(TMO));
        checkOutput("t4_late_tmo",    32'(rsp_timeout), 32'd0);
        checkOutput("t4_late_result", 32'(rsp_result),  32'h50);
        @(negedge clk);

`ifdef ALU_SEQ_STATS_EN
        checkOutput("stat_cmd", 32'(stat_cmd_cnt), 32'd9);
        checkOutput("stat_ovf", 32'(stat_ovf_cnt), 32'd2);
        checkOutput("stat_tmo", 32'(stat_tmo_cnt), 32'd1);
`endif

        // Reset during SEND_B with two commands still queued.
        alu_delay = 0;
        applyStimulus(1'b0, 8'h11, 8'h22);
        applyStimulus(1'b0, 8'h33, 8'h44);
        applyStimulus(1'b0, 8'h55, 8'h66);
        checkOutput("t5_in_sendb_valid", 32'(opcode_valid), 32'd1);
        checkOutput("t5_in_sendb_data",  32'(data),         32'h22);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("t5_rst_opcode_valid", 32'(opcode_valid), 32'd0);
        checkOutput("t5_rst_cmd_ready",    32'(cmd_ready),    32'd1);
        checkOutput("t5_rst_rsp_valid",    32'(rsp_valid),    32'd0);
        checkOutput("t5_rst_data",         32'(data),         32'd0);
`ifdef ALU_SEQ_STATS_EN
        checkOutput("t5_rst_stat_cmd", 32'(stat_cmd_cnt), 32'd0);
`endif
        reset = 1'b0;
        seen_rsp = 0;
        seen_op  = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (rsp_valid) seen_rsp++;
            if (opcode_valid) seen_op++;
        end
        checkOutput("t5_no_rsp",   32'(seen_rsp),  32'd0);
        checkOutput("t5_no_issue", 32'(seen_op),   32'd0);
        checkOutput("t5_ready",    32'(cmd_ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
